// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exponent mod modulus.
// Optional watchdog on the modulo-unit handshake: define MODEXP_TIMEOUT_EN.
module modexp_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0]      exponent,
    input  logic [DATA_WIDTH-1:0]     modulus,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      err,
    output logic [2*DATA_WIDTH:0]     mod_a,
    output logic [DATA_WIDTH-1:0]     mod_m,
    output logic                      mod_start,
    input  logic [DATA_WIDTH-1:0]     mod_out,
    input  logic                      mod_done
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
`ifdef MODEXP_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = 4 * DATA_WIDTH + 8;
    localparam int unsigned WW       = $clog2(TO_LIMIT + 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RED_BASE,
        SQUARE,
        MULTIPLY,
        WAIT_MOD,
        FINISH
    } state_t;

    state_t                state;
    state_t                ret_state;
    logic [DATA_WIDTH-1:0] base_q;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic [DATA_WIDTH-1:0] mod_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] b_q;
    logic [IW-1:0]         idx;
    logic                  tgt_b;
`ifdef MODEXP_TIMEOUT_EN
    logic [WW-1:0]         wd;
`endif

    logic [PW-1:0]         prod_c;
    logic                  bypass_c;
    logic                  dec_c;
    state_t                after_c;

    assign mod_m = mod_q;

    // Product of the current step and the state that follows it once reduced
    always_comb begin
        prod_c = '0;
        unique case (state)
            RED_BASE: prod_c = PW'(base_q);
            SQUARE:   prod_c = PW'(acc) * PW'(acc);
            MULTIPLY: prod_c = PW'(acc) * PW'(b_q);
            default:  prod_c = '0;
        endcase
        bypass_c = prod_c < PW'(mod_q);

        after_c = SQUARE;
        if (state == RED_BASE) begin
            after_c = SQUARE;
        end else if (state == SQUARE && exp_q[idx]) begin
            after_c = MULTIPLY;
        end else if (idx == '0) begin
            after_c = FINISH;
        end else begin
            after_c = SQUARE;
        end
        dec_c = (state == SQUARE || state == MULTIPLY) && (after_c == SQUARE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            mod_a     <= '0;
            mod_start <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            acc       <= '0;
            b_q       <= '0;
            idx       <= '0;
            tgt_b     <= 1'b0;
`ifdef MODEXP_TIMEOUT_EN
            wd        <= '0;
`endif
        end else begin
            done      <= 1'b0;
            mod_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        mod_q  <= modulus;
                        acc    <= DATA_WIDTH'(1);
                        idx    <= IW'(EXP_WIDTH - 1);
                        busy   <= 1'b1;
                        result <= '0;
                        err    <= 1'b0;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (mod_q == '0) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= FINISH;
                    end else if (mod_q == DATA_WIDTH'(1)) begin
                        result <= '0;
                        state  <= FINISH;
                    end else begin
                        state  <= RED_BASE;
                    end
                end
                RED_BASE, SQUARE, MULTIPLY: begin
                    if (dec_c) begin
                        idx <= idx - IW'(1);
                    end
                    // Products already below the modulus never reach the modulo unit
                    if (bypass_c) begin
                        if (state == RED_BASE) begin
                            b_q <= DATA_WIDTH'(prod_c);
                        end else begin
                            acc <= DATA_WIDTH'(prod_c);
                        end
                        if (after_c == FINISH) begin
                            result <= DATA_WIDTH'(prod_c);
                        end
                        state <= after_c;
                    end else begin
                        mod_a     <= AW'(prod_c);
                        mod_start <= 1'b1;
                        ret_state <= after_c;
                        tgt_b     <= (state == RED_BASE);
                        state     <= WAIT_MOD;
`ifdef MODEXP_TIMEOUT_EN
                        wd        <= '0;
`endif
                    end
                end
                WAIT_MOD: begin
                    // mod_done may still be high from the previous reduction while mod_start is out
                    if (!mod_start && mod_done) begin
                        if (tgt_b) begin
                            b_q <= mod_out;
                        end else begin
                            acc <= mod_out;
                        end
                        if (ret_state == FINISH) begin
                            result <= mod_out;
                        end
                        state <= ret_state;
                    end
`ifdef MODEXP_TIMEOUT_EN
                    else if (wd == WW'(TO_LIMIT - 1)) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= FINISH;
                    end else begin
                        wd <= wd + WW'(1);
                    end
`endif
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Sequencer computing result = base^exponent mod modulus by left-to-right square-and-multiply. Owns a DATA_WIDTH x DATA_WIDTH multiplier. Time-shares one external shift-subtract modulo unit through its start/done handshake. Sits between the crypto top level and the modulo datapath; one operation in flight at a time.

Parameters:
DATA_WIDTH, 8, width of base, modulus, result and the modulo unit's residue
EXP_WIDTH, 8, width of exponent; number of scanned exponent bits

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
base  input  DATA_WIDTH  operand, latched on accepted start
exponent  input  EXP_WIDTH  exponent, latched on accepted start
modulus  input  DATA_WIDTH  modulus, latched on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; result and err valid
result  output  DATA_WIDTH  final residue, held until the next accepted start
err  output  1  set with done when modulus==0; held with result
mod_a  output  2*DATA_WIDTH+1  dividend to modulo unit, registered, stable until mod_done
mod_m  output  DATA_WIDTH  modulus to modulo unit, equals latched modulus
mod_start  output  1  registered one-cycle pulse to modulo unit
mod_out  input  DATA_WIDTH  residue from modulo unit
mod_done  input  1  level from modulo unit, low after mod_start, high when finished

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on reset_n. Reset values: busy=0, done=0, result=0, err=0, mod_a=0, mod_start=0, state=IDLE. Reset mid-operation aborts immediately. No mod_start is issued after reset until a new start.
- States: IDLE, CHECK, RED_BASE, SQUARE, MULTIPLY, WAIT_MOD, FINISH. A return-state register selects the successor of WAIT_MOD.
- IDLE: on start, latch operands, acc<=1, bit index i<=EXP_WIDTH-1, go to CHECK. start is ignored in every other state.
- CHECK, modulus==0: err<=1, result<=0, go to FINISH.
- CHECK, modulus==1: result<=0, go to FINISH.
- CHECK, otherwise: go to RED_BASE.
- RED_BASE: b<=base mod modulus.
- SQUARE: p=acc*acc, 2*DATA_WIDTH bits, zero-extended to mod_a width.
  - Next state is MULTIPLY if exponent[i]==1.
  - Otherwise decrement i; after i==0, go to FINISH with result<=acc.
- MULTIPLY: p=acc*b. Then the same index and exit rule as SQUARE.
- Reduction rule (RED_BASE, SQUARE, MULTIPLY):
  - Bypass: if p < modulus, the target register takes p in the same cycle. No mod_start is issued; the step costs 1 cycle. Bypass is mandatory: the modulo unit never receives a dividend smaller than its modulant.
  - Otherwise: mod_a<=p, mod_start<=1 for exactly one cycle, go to WAIT_MOD.
- WAIT_MOD:
  - mod_done is ignored in the first cycle, while mod_start is high.
  - From the second cycle on, the first cycle with mod_done==1 writes mod_out into acc or b, then moves to the return state.
  - mod_a is held constant throughout.
- FINISH: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Exponent==0 yields result 1 (modulus>=2). All EXP_WIDTH bits are scanned; leading zeros are squared as 1 via bypass.
- Width rule: acc and b are always < modulus, so p <= (2^DATA_WIDTH-1)^2 and fits in mod_a.

Optional Feature:
MODEXP_TIMEOUT_EN:
- Defined: WAIT_MOD runs a watchdog counter. If mod_done has not arrived after 4*DATA_WIDTH+8 cycles, the controller aborts: err<=1, result<=0, goes to FINISH, and done pulses.
- Not defined: no counter; WAIT_MOD waits indefinitely.

Test Plan:
- DATA_WIDTH=8, base=3, exponent=5, modulus=7 -> done pulse, result=5, err=0; every mod_start is one cycle wide.
- base=200, exponent=3, modulus=13 -> base reduction via modulo unit gives 5; final result=8.
- base=2, exponent=3, modulus=251 -> result=8 with zero mod_start pulses (all bypass).
- exponent=0, modulus=7 -> result=1. Modulus=1 -> result=0, err=0. Modulus=0 -> result=0, err=1; no mod_start in any of the three.
- start pulsed again while busy with different operands -> ignored; first result unchanged. Assert reset_n low mid-WAIT_MOD -> busy/done/mod_start drop at once; the next start runs correctly.
- MODEXP_TIMEOUT_EN defined, stub never raises mod_done -> done with err=1 exactly 4*DATA_WIDTH+8 cycles into WAIT_MOD.
